// File: rtl/input_sram_arbiter.sv
// Arbitrates one writer and NUM_RD round-robin readers onto a single SRAM controller port.
// One transaction in flight at a time; out-of-range addresses are answered with an error, never issued.
module input_sram_arbiter #(
   parameter int unsigned NUM_RD       = 4,
   parameter int unsigned WR_BURST_MAX = 4,
   parameter int unsigned ADDR_LIMIT   = 12288,
   parameter int unsigned WAIT_MAX     = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wr_req,
   input  logic [31:0]          wr_addr,
   input  logic [127:0]         wr_data,
   output logic                 wr_ack,
   output logic                 wr_err,
   input  logic [NUM_RD-1:0]    rd_req,
   input  logic [NUM_RD*32-1:0] rd_addr,
   output logic [NUM_RD-1:0]    rd_ack,
   output logic                 rd_err,
   output logic [127:0]         rd_data,
   output logic [31:0]          sram_w_addr,
   output logic [127:0]         sram_w_d,
   output logic [31:0]          sram_r_addr,
   output logic                 sram_w_en,
   output logic                 sram_r_en,
   input  logic [127:0]         sram_r_d,
   input  logic                 sram_d_ready,
   input  logic                 sram_w_done
);

   localparam int unsigned PtrW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int unsigned BurstW = $clog2(WR_BURST_MAX + 1);
   localparam int unsigned WaitW  = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q;
   logic [PtrW-1:0]   rr_ptr_q;
   logic [BurstW-1:0] burst_q;
   logic [WaitW-1:0]  wait_q;
   logic              op_wr_q;
   logic [PtrW-1:0]   op_id_q;
   logic              reject_q;

   logic              any_rd;
   logic              rd_found;
   logic [PtrW-1:0]   rd_win;
   logic [31:0]       win_rd_addr;
   logic              burst_full;
   logic              grant_wr;
   logic [31:0]       win_addr;
   logic              win_bad;
   logic              done_hit;
   logic              timeout;
   logic              resp_go;
   logic              resp_err;

   // Round-robin search starting at rr_ptr_q, wrapping at NUM_RD-1.
   always_comb begin
      int idx;
      idx      = 0;
      rd_found = 1'b0;
      rd_win   = '0;
      for (int k = 0; k < int'(NUM_RD); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(NUM_RD)) idx = idx - int'(NUM_RD);
         if (!rd_found && rd_req[PtrW'(idx)]) begin
            rd_found = 1'b1;
            rd_win   = PtrW'(idx);
         end
      end
   end

   always_comb begin
      win_rd_addr = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         if (rd_win == PtrW'(i)) win_rd_addr = rd_addr[32*i +: 32];
      end
   end

   assign any_rd     = |rd_req;
   assign burst_full = (burst_q == BurstW'(WR_BURST_MAX));
   assign grant_wr   = wr_req && !(burst_full && any_rd);
   assign win_addr   = grant_wr ? wr_addr : win_rd_addr;
   assign win_bad    = (win_addr >= ADDR_LIMIT);

   // Strobes of the other operation type never complete the pending one.
   assign done_hit = op_wr_q ? sram_w_done : sram_d_ready;
   assign timeout  = (wait_q == WaitW'(WAIT_MAX - 1));
   assign resp_go  = ((state_q == StIssue) && reject_q) ||
                     ((state_q == StWait) && (done_hit || timeout));
   assign resp_err = (state_q == StIssue) || !done_hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         burst_q     <= '0;
         wait_q      <= '0;
         op_wr_q     <= 1'b0;
         op_id_q     <= '0;
         reject_q    <= 1'b0;
         wr_ack      <= 1'b0;
         wr_err      <= 1'b0;
         rd_ack      <= '0;
         rd_err      <= 1'b0;
         rd_data     <= '0;
         sram_w_addr <= '0;
         sram_w_d    <= '0;
         sram_r_addr <= '0;
         sram_w_en   <= 1'b0;
         sram_r_en   <= 1'b0;
      end else begin
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
         rd_ack    <= '0;
         rd_err    <= 1'b0;
         sram_w_en <= 1'b0;
         sram_r_en <= 1'b0;
         if (!any_rd) burst_q <= '0;

         unique case (state_q)
            StIdle: begin
               if (wr_req || any_rd) begin
                  // Rejected requests pass one cycle through StIssue with no enable.
                  state_q  <= StIssue;
                  op_wr_q  <= grant_wr;
                  op_id_q  <= rd_win;
                  reject_q <= win_bad;
                  if (grant_wr) begin
                     // A write wins with reads pending only while burst_q < WR_BURST_MAX.
                     if (any_rd) burst_q <= burst_q + BurstW'(1);
                     if (!win_bad) begin
                        sram_w_en   <= 1'b1;
                        sram_w_addr <= wr_addr;
                        sram_w_d    <= wr_data;
                     end
                  end else begin
                     burst_q  <= '0;
                     rr_ptr_q <= (rd_win == PtrW'(NUM_RD - 1)) ? '0 : rd_win + PtrW'(1);
                     if (!win_bad) begin
                        sram_r_en   <= 1'b1;
                        sram_r_addr <= win_rd_addr;
                     end
                  end
               end
            end
            StIssue: begin
               wait_q <= '0;
               if (!reject_q) state_q <= StWait;
            end
            StWait: wait_q <= wait_q + WaitW'(1);
            StResp: state_q <= StIdle;
         endcase

         if (resp_go) begin
            state_q <= StResp;
            if (op_wr_q) begin
               wr_ack <= 1'b1;
               wr_err <= resp_err;
            end else begin
               rd_ack[op_id_q] <= 1'b1;
               rd_err          <= resp_err;
               rd_data         <= resp_err ? '0 : sram_r_d;
            end
         end
      end
   end

   a_rd_ack_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(rd_ack));
   a_ack_exclusive: assert property (@(posedge clock) disable iff (reset) !(wr_ack && |rd_ack));
   a_en_exclusive:  assert property (@(posedge clock) disable iff (reset) !(sram_w_en && sram_r_en));

endmodule
